// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: lamp colours, driver FSM states, fault codes.
package traffic_pkg;

  localparam int unsigned LAMP_W = 3;
  localparam int unsigned CODE_W = 2;

  localparam logic [LAMP_W-1:0] RED    = 3'b100;
  localparam logic [LAMP_W-1:0] YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] GREEN  = 3'b001;
  localparam logic [LAMP_W-1:0] OFF    = 3'b000;

  localparam logic [CODE_W-1:0] FC_NONE     = 2'b00;
  localparam logic [CODE_W-1:0] FC_ENCODING = 2'b01;
  localparam logic [CODE_W-1:0] FC_CONFLICT = 2'b10;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    NORMAL  = 2'd1,
    FAULT   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  function automatic logic is_one_hot(input logic [LAMP_W-1:0] code);
    return (code == RED) || (code == YELLOW) || (code == GREEN);
  endfunction

endpackage

// File: rtl/traffic_lamp_driver_if.sv
// Controller-to-lamp-driver signal bundle.
interface traffic_lamp_driver_if;
  import traffic_pkg::*;

  logic [LAMP_W-1:0] ns_in;
  logic [LAMP_W-1:0] ew_in;
  logic              fault_clr;
  logic [LAMP_W-1:0] ns_lamp;
  logic [LAMP_W-1:0] ew_lamp;
  logic              fault;
  logic [CODE_W-1:0] fault_code;

  modport master (
    output ns_in, ew_in, fault_clr,
    input  ns_lamp, ew_lamp, fault, fault_code
  );

  modport slave (
    input  ns_in, ew_in, fault_clr,
    output ns_lamp, ew_lamp, fault, fault_code
  );
endinterface

// File: rtl/tl_blink_gen.sv
// Blink phase generator; phase_c is the phase that will hold after the next edge (1 = ON).
module tl_blink_gen #(
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase_c
);
  localparam int unsigned CW = $clog2(BLINK_HALF + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          phase;
  logic          phase_next;

  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (clr) begin
      cnt_next   = CW'(0);
      phase_next = 1'b1;
    end else if (en) begin
      if (cnt == CW'(BLINK_HALF - 1)) begin
        cnt_next   = CW'(0);
        phase_next = ~phase;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= CW'(0);
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

  assign phase_c = phase_next;
endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver and conflict monitor: passes legal codes, latches faults, flashes yellow, all-red clearance.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int unsigned FAULT_PERSIST = 2,
  parameter int unsigned BLINK_HALF    = 4,
  parameter int unsigned ALLRED_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rst,
  traffic_lamp_driver_if.slave bus
);
  localparam int unsigned PW = $clog2(FAULT_PERSIST + 1);
  localparam int unsigned TW = $clog2(ALLRED_CYCLES + 1);

  state_t            state;
  state_t            state_next;
  logic [PW-1:0]     persist;
  logic [PW-1:0]     persist_next;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_next;
  logic [LAMP_W-1:0] ns_next;
  logic [LAMP_W-1:0] ew_next;
  logic              fault_next;
  logic [CODE_W-1:0] code_next;

  logic enc_err;
  logic conflict;
  logic illegal;
  logic trip;
  logic timeout;
  logic phase_c;

  assign enc_err  = !is_one_hot(bus.ns_in) || !is_one_hot(bus.ew_in);
  assign conflict = !enc_err && (bus.ns_in != RED) && (bus.ew_in != RED);
  assign illegal  = enc_err || conflict;
  assign trip     = (state != FAULT) && illegal && (persist == PW'(FAULT_PERSIST - 1));
  assign timeout  = (timer == TW'(ALLRED_CYCLES - 1));

  tl_blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .en     (state == FAULT),
    .clr    (state != FAULT),
    .phase_c(phase_c)
  );

  // Next state, counters and lamp drive; lamps follow the state being entered.
  always_comb begin
    state_next   = state;
    persist_next = PW'(0);
    timer_next   = TW'(0);
    fault_next   = bus.fault;
    code_next    = bus.fault_code;

    if ((state != FAULT) && illegal) persist_next = persist + PW'(1);

    case (state)
      STARTUP, RECOVER: begin
        if (timeout) state_next = NORMAL;
        else         timer_next = timer + TW'(1);
      end
      NORMAL: ;
      FAULT: begin
        if (bus.fault_clr && !illegal) begin
          state_next = RECOVER;
          fault_next = 1'b0;
          code_next  = FC_NONE;
        end
      end
      default: state_next = STARTUP;
    endcase

    if (trip) begin
      state_next   = FAULT;
      persist_next = PW'(0);
      timer_next   = TW'(0);
      fault_next   = 1'b1;
      code_next    = {conflict, enc_err};
    end

    case (state_next)
      NORMAL: begin
        ns_next = bus.ns_in;
        ew_next = bus.ew_in;
      end
      FAULT: begin
        ns_next = phase_c ? YELLOW : OFF;
        ew_next = phase_c ? YELLOW : OFF;
      end
      default: begin
        ns_next = RED;
        ew_next = RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STARTUP;
      persist <= PW'(0);
      timer   <= TW'(0);
    end else begin
      state   <= state_next;
      persist <= persist_next;
      timer   <= timer_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ns_lamp    <= RED;
      bus.ew_lamp    <= RED;
      bus.fault      <= 1'b0;
      bus.fault_code <= FC_NONE;
    end else begin
      bus.ns_lamp    <= ns_next;
      bus.ew_lamp    <= ew_next;
      bus.fault      <= fault_next;
      bus.fault_code <= code_next;
    end
  end
endmodule
